// File: rtl/simple_st0_mem_ctrl_pkg.sv
// Shared definitions for the stage-0 memory-bank sequencer: selector codes,
// FSM states, default address widths and the packed memory-port layouts.
package simple_st0_mem_ctrl_pkg;

   localparam int DATA_AW_DEF = 6;
   localparam int TAP_AW_DEF  = 4;
   localparam int BIAS_AW_DEF = 4;

   localparam int DATA_W = 32;
   localparam int TAP_W  = 192;
   localparam int BIAS_W = 32;

   typedef enum logic [1:0] {
      SEL_DATA = 2'd0,
      SEL_TAP  = 2'd1,
      SEL_BIAS = 2'd2,
      SEL_RSVD = 2'd3
   } mem_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_BIAS = 2'd2
   } state_e;

   // Port layouts the surrounding top level uses to pack the per-memory lines.
   typedef struct packed {
      logic [DATA_W-1:0]      wr_data;
      logic [DATA_AW_DEF-1:0] addr;
      logic                   rd_en;
      logic                   wr_en;
   } data_int_32_6_t;

   typedef struct packed {
      logic [TAP_W-1:0]      wr_data;
      logic [TAP_AW_DEF-1:0] addr;
      logic                  rd_en;
      logic                  wr_en;
   } tap_int_192_4_t;

   typedef struct packed {
      logic [BIAS_W-1:0]      wr_data;
      logic [BIAS_AW_DEF-1:0] addr;
      logic                   rd_en;
      logic                   wr_en;
   } bias_int_32_4_t;

endpackage

// File: rtl/simple_st0_mem_ctrl_if.sv
// Control/handshake bundle between the host side and the memory sequencer.
// master = host/stimulus side, slave = the sequencer.
interface simple_st0_mem_ctrl_if
   import simple_st0_mem_ctrl_pkg::*;
#(
   parameter int DATA_AW = DATA_AW_DEF,
   parameter int TAP_AW  = TAP_AW_DEF,
   parameter int BIAS_AW = BIAS_AW_DEF
);
   logic               start;
   logic               abort;
   logic [DATA_AW-1:0] cfg_len;
   logic [BIAS_AW-1:0] cfg_outputs;
   logic               host_wr_valid;
   logic [1:0]         host_wr_sel;
   logic [DATA_AW-1:0] host_wr_addr;
   logic               host_wr_ready;

   logic [DATA_AW-1:0] data_addr;
   logic               data_rd_en;
   logic               data_wr_en;
   logic [TAP_AW-1:0]  tap_addr;
   logic               tap_rd_en;
   logic               tap_wr_en;
   logic [BIAS_AW-1:0] bias_addr;
   logic               bias_rd_en;
   logic               bias_wr_en;

   logic               mac_valid;
   logic               mac_first;
   logic               mac_last;
   logic               bias_valid;
   logic               busy;
   logic               done;

   modport master (
      output start, abort, cfg_len, cfg_outputs,
      output host_wr_valid, host_wr_sel, host_wr_addr,
      input  host_wr_ready,
      input  data_addr, data_rd_en, data_wr_en,
      input  tap_addr, tap_rd_en, tap_wr_en,
      input  bias_addr, bias_rd_en, bias_wr_en,
      input  mac_valid, mac_first, mac_last, bias_valid, busy, done
   );

   modport slave (
      input  start, abort, cfg_len, cfg_outputs,
      input  host_wr_valid, host_wr_sel, host_wr_addr,
      output host_wr_ready,
      output data_addr, data_rd_en, data_wr_en,
      output tap_addr, tap_rd_en, tap_wr_en,
      output bias_addr, bias_rd_en, bias_wr_en,
      output mac_valid, mac_first, mac_last, bias_valid, busy, done
   );

endinterface

// File: rtl/simple_st0_mem_ctrl_pipe.sv
// One-cycle strobe alignment register: delays the read enables to line up
// with memory read data, and drops everything in flight on a flush.
module simple_st0_mem_ctrl_pipe (
   input  logic clk,
   input  logic reset,
   input  logic flush_i,
   input  logic mac_rd_i,
   input  logic first_rd_i,
   input  logic last_rd_i,
   input  logic bias_rd_i,
   input  logic final_i,
   output logic mac_valid_o,
   output logic mac_first_o,
   output logic mac_last_o,
   output logic bias_valid_o,
   output logic done_o
);

   typedef struct packed {
      logic mac_valid;
      logic mac_first;
      logic mac_last;
      logic bias_valid;
      logic done;
   } strobe_t;

   strobe_t strobe_q;
   strobe_t strobe_d;

   always_comb begin
      strobe_d = '0;
      if (!flush_i) begin
         strobe_d.mac_valid  = mac_rd_i;
         strobe_d.mac_first  = mac_rd_i & first_rd_i;
         strobe_d.mac_last   = mac_rd_i & last_rd_i;
         strobe_d.bias_valid = bias_rd_i;
         strobe_d.done       = bias_rd_i & final_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         strobe_q <= '0;
      end else begin
         strobe_q <= strobe_d;
      end
   end

   assign mac_valid_o  = strobe_q.mac_valid;
   assign mac_first_o  = strobe_q.mac_first;
   assign mac_last_o   = strobe_q.mac_last;
   assign bias_valid_o = strobe_q.bias_valid;
   assign done_o       = strobe_q.done;

endmodule

// File: rtl/simple_st0_mem_ctrl.sv
// Stage-0 tap/bias/data memory sequencer: host writes while idle, then walks
// data+tap per neuron followed by its bias. Optional SIMPLE_ST0_MEM_CTRL_PERF_EN adds run_cycles.
module simple_st0_mem_ctrl
   import simple_st0_mem_ctrl_pkg::*;
#(
   parameter int DATA_AW = DATA_AW_DEF,
   parameter int TAP_AW  = TAP_AW_DEF,
   parameter int BIAS_AW = BIAS_AW_DEF
) (
   input  logic clk,
   input  logic reset,
   simple_st0_mem_ctrl_if.slave bus
`ifdef SIMPLE_ST0_MEM_CTRL_PERF_EN
   ,
   output logic [15:0] run_cycles
`endif
);

   state_e             state_q, state_d;
   logic [DATA_AW-1:0] in_cnt_q, in_cnt_d;
   logic [DATA_AW-1:0] len_q, len_d;
   logic [BIAS_AW-1:0] out_cnt_q, out_cnt_d;
   logic [BIAS_AW-1:0] outputs_q, outputs_d;
   logic [TAP_AW-1:0]  tap_ptr_q, tap_ptr_d;
   logic               live_q;

   logic               mac_rd;
   logic               first_rd;
   logic               last_rd;
   logic               bias_rd;
   logic               final_bias;
   logic               flush;
   logic               done_w;
   logic               idle_accept;
   logic               run_start;

   // live_q keeps host-facing outputs low until the first clock after reset
   // release; done_w holds them off for the done cycle, which still counts as busy.
   assign idle_accept = live_q & ~done_w;
   assign run_start   = (state_q == ST_IDLE) & idle_accept & bus.start;

   always_comb begin
      state_d        = state_q;
      in_cnt_d       = in_cnt_q;
      len_d          = len_q;
      out_cnt_d      = out_cnt_q;
      outputs_d      = outputs_q;
      tap_ptr_d      = tap_ptr_q;
      mac_rd         = 1'b0;
      first_rd       = 1'b0;
      last_rd        = 1'b0;
      bias_rd        = 1'b0;
      final_bias     = 1'b0;
      flush          = 1'b0;
      bus.host_wr_ready = 1'b0;
      bus.data_addr  = '0;
      bus.data_rd_en = 1'b0;
      bus.data_wr_en = 1'b0;
      bus.tap_addr   = '0;
      bus.tap_rd_en  = 1'b0;
      bus.tap_wr_en  = 1'b0;
      bus.bias_addr  = '0;
      bus.bias_rd_en = 1'b0;
      bus.bias_wr_en = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bus.host_wr_ready = idle_accept;
            if (idle_accept && bus.host_wr_valid) begin
               case (mem_sel_e'(bus.host_wr_sel))
                  SEL_DATA: begin
                     bus.data_wr_en = 1'b1;
                     bus.data_addr  = bus.host_wr_addr;
                  end
                  SEL_TAP: begin
                     bus.tap_wr_en = 1'b1;
                     bus.tap_addr  = bus.host_wr_addr[TAP_AW-1:0];
                  end
                  SEL_BIAS: begin
                     bus.bias_wr_en = 1'b1;
                     bus.bias_addr  = bus.host_wr_addr[BIAS_AW-1:0];
                  end
                  default: ;
               endcase
            end
            if (run_start) begin
               len_d     = bus.cfg_len;
               outputs_d = bus.cfg_outputs;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               tap_ptr_d = '0;
               state_d   = ST_RUN;
            end
         end

         ST_RUN: begin
            bus.data_rd_en = 1'b1;
            bus.tap_rd_en  = 1'b1;
            bus.data_addr  = in_cnt_q;
            bus.tap_addr   = tap_ptr_q;
            mac_rd         = 1'b1;
            first_rd       = (in_cnt_q == '0);
            last_rd        = (in_cnt_q == len_q);
            tap_ptr_d      = tap_ptr_q + 1'b1;
            if (last_rd) begin
               in_cnt_d = '0;
               state_d  = ST_BIAS;
            end else begin
               in_cnt_d = in_cnt_q + 1'b1;
            end
            if (bus.abort) begin
               flush   = 1'b1;
               state_d = ST_IDLE;
            end
         end

         ST_BIAS: begin
            bus.bias_rd_en = 1'b1;
            bus.bias_addr  = out_cnt_q;
            bias_rd        = 1'b1;
            if (out_cnt_q == outputs_q) begin
               final_bias = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               out_cnt_d = out_cnt_q + 1'b1;
               state_d   = ST_RUN;
            end
            if (bus.abort) begin
               flush   = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         in_cnt_q  <= '0;
         len_q     <= '0;
         out_cnt_q <= '0;
         outputs_q <= '0;
         tap_ptr_q <= '0;
         live_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         len_q     <= len_d;
         out_cnt_q <= out_cnt_d;
         outputs_q <= outputs_d;
         tap_ptr_q <= tap_ptr_d;
         live_q    <= 1'b1;
      end
   end

   simple_st0_mem_ctrl_pipe u_pipe (
      .clk          (clk),
      .reset        (reset),
      .flush_i      (flush),
      .mac_rd_i     (mac_rd),
      .first_rd_i   (first_rd),
      .last_rd_i    (last_rd),
      .bias_rd_i    (bias_rd),
      .final_i      (final_bias),
      .mac_valid_o  (bus.mac_valid),
      .mac_first_o  (bus.mac_first),
      .mac_last_o   (bus.mac_last),
      .bias_valid_o (bus.bias_valid),
      .done_o       (done_w)
   );

   assign bus.done = done_w;
   assign bus.busy = (state_q != ST_IDLE) | done_w;

`ifdef SIMPLE_ST0_MEM_CTRL_PERF_EN
   logic [15:0] run_cycles_q, run_cycles_d;

   always_comb begin
      run_cycles_d = run_cycles_q;
      if (run_start) begin
         run_cycles_d = '0;
      end else if (bus.busy && (run_cycles_q != 16'hFFFF)) begin
         run_cycles_d = run_cycles_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cycles_q <= '0;
      end else begin
         run_cycles_q <= run_cycles_d;
      end
   end

   assign run_cycles = run_cycles_q;
`endif

endmodule
